// File: rtl/sign_narrower.sv
// sign_narrower: saturating signed width reducer with 2-entry skid buffer and clamp statistics
module sign_narrower #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output logic [CNT_W-1:0] sat_count,
  output logic             sat_sticky,
  input  logic             clr_stats
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state, state_n;
  logic [IN_W-OUT_W:0] hi;
  logic [OUT_W-1:0] nar, skid_data;
  logic fits, sat, acc, pop, skid_sat, load_main, load_skid;
  assign hi = in_data[IN_W-1:OUT_W-1];
  assign fits = (&hi) | ~(|hi);
  assign sat = ~fits;
  assign nar = fits ? in_data[OUT_W-1:0] :
               in_data[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  assign acc = in_valid & in_ready;
  assign out_valid = state != EMPTY;
  assign pop = out_valid & out_ready;
  assign load_main = ((state == EMPTY) & acc) | ((state == ONE) & acc & pop) | ((state == TWO) & pop);
  assign load_skid = (state == ONE) & acc & ~pop;
  always_comb begin
    state_n = state;
    case (state)
      EMPTY:   state_n = acc ? ONE : EMPTY;
      ONE:     state_n = (acc & ~pop) ? TWO : (~acc & pop) ? EMPTY : ONE;
      TWO:     state_n = pop ? ONE : TWO;
      default: state_n = EMPTY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      in_ready <= 1'b0;
      out_data <= '0;
      out_sat <= 1'b0;
      skid_data <= '0;
      skid_sat <= 1'b0;
    end else begin
      state <= state_n;
      in_ready <= state_n != TWO;
      if (load_main) {out_sat, out_data} <= (state == TWO) ? {skid_sat, skid_data} : {sat, nar};
      if (load_skid) {skid_sat, skid_data} <= {sat, nar};
    end
  end
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      sat_count <= '0;
      sat_sticky <= 1'b0;
    end else if (acc && sat) begin
      sat_count <= (&sat_count) ? sat_count : sat_count + CNT_W'(1);
      sat_sticky <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sign_narrower.sv
// tb_sign_narrower: randomized and directed checks of sign_narrower against a queue-based reference
module tb_sign_narrower;
  localparam int IN_W = 8, OUT_W = 4, CNT_W = 8;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1, clr_stats = 0;
  logic [IN_W-1:0] in_data = '0;
  logic in_ready, out_valid, out_sat, sat_sticky;
  logic [OUT_W-1:0] out_data;
  logic [CNT_W-1:0] sat_count;
  int errors = 0, checks = 0;
  logic [OUT_W:0] q[$];
  int m_cnt = 0;
  logic m_sticky = 0, m_rdy = 0;
  sign_narrower #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .sat_count(sat_count), .sat_sticky(sat_sticky), .clr_stats(clr_stats)
  );
  always #5 clk = ~clk;
  function automatic logic [OUT_W:0] ref_narrow(input logic [IN_W-1:0] x);
    int v, lo, hi;
    v = int'($signed(x));
    lo = -(1 << (OUT_W - 1));
    hi = (1 << (OUT_W - 1)) - 1;
    if (v > hi) return {1'b1, hi[OUT_W-1:0]};
    if (v < lo) return {1'b1, lo[OUT_W-1:0]};
    return {1'b0, v[OUT_W-1:0]};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    logic [OUT_W:0] e;
    logic acc, pop;
    chk("in_ready", in_ready, m_rdy);
    chk("out_valid", out_valid, q.size() != 0);
    chk("sat_count", sat_count, m_cnt);
    chk("sat_sticky", sat_sticky, m_sticky);
    acc = in_valid && m_rdy;
    pop = out_ready && q.size() != 0;
    if (rst) begin
      q.delete();
      m_cnt = 0;
      m_sticky = 0;
      m_rdy = 0;
    end else begin
      if (pop) begin
        e = q.pop_front();
        chk("out_stream", {out_sat, out_data}, e);
      end
      e = ref_narrow(in_data);
      if (acc) q.push_back(e);
      if (clr_stats) begin
        m_cnt = 0;
        m_sticky = 0;
      end else if (acc && e[OUT_W]) begin
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        m_sticky = 1;
      end
      m_rdy = q.size() < 2;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [IN_W-1:0] x);
    int n = 0;
    logic ok = 0;
    in_valid = 1;
    in_data = x;
    do begin
      @(negedge clk);
      ok = in_ready;
      tick();
      n++;
    end while (!ok && n < 200);
    in_valid = 0;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: data %0h not accepted within 200 cycles", x);
    end
  endtask
  initial begin
    bit done;
    chk("pin_05", ref_narrow(8'h05), 5'h05);
    chk("pin_FB", ref_narrow(8'hFB), 5'h0B);
    chk("pin_07", ref_narrow(8'h07), 5'h07);
    chk("pin_08", ref_narrow(8'h08), 5'h17);
    chk("pin_F8", ref_narrow(8'hF8), 5'h08);
    chk("pin_F7", ref_narrow(8'hF7), 5'h18);
    chk("pin_80", ref_narrow(8'h80), 5'h18);
    chk("pin_7F", ref_narrow(8'h7F), 5'h17);
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_sat_count", sat_count, 0);
    chk("rst_sat_sticky", sat_sticky, 0);
    rst = 0;
    tick();
    chk("ready_after_rst", in_ready, 1);
    for (int i = 0; i < 256; i++) send(i[IN_W-1:0]);
    chk("sweep_count", sat_count, 240);
    chk("sweep_sticky", sat_sticky, 1);
    repeat (3) tick();
    out_ready = 0;
    send(8'h01);
    send(8'h02);
    chk("bp_in_ready", in_ready, 0);
    in_valid = 1;
    in_data = 8'h03;
    repeat (3) tick();
    chk("bp_hold_ready", in_ready, 0);
    chk("bp_head_data", out_data, 4'h1);
    chk("bp_head_valid", out_valid, 1);
    out_ready = 1;
    send(8'h03);
    repeat (4) tick();
    chk("bp_drained", q.size(), 0);
    done = 0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(3) == 0) repeat ($urandom_range(2)) tick();
          send($urandom_range(255));
        end
        done = 1;
      end
      begin
        while (!done) begin
          out_ready = $urandom_range(1);
          tick();
        end
      end
    join
    out_ready = 1;
    repeat (5) tick();
    chk("rand_drained", q.size(), 0);
    for (int i = 0; i < 300; i++) send(8'h40);
    chk("sat_cap", sat_count, 255);
    clr_stats = 1;
    send(8'h40);
    clr_stats = 0;
    chk("clr_count", sat_count, 0);
    chk("clr_sticky", sat_sticky, 0);
    repeat (3) tick();
    out_ready = 0;
    send(8'h40);
    send(8'h41);
    chk("full_ready", in_ready, 0);
    chk("full_count", sat_count, 2);
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_count", sat_count, 0);
    tick();
    chk("post_rst_ready", in_ready, 1);
    out_ready = 1;
    repeat (3) tick();
    chk("no_stale", out_valid, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
